// File: rtl/fixed_p_smult_rr_sched.sv
// fixed_p_smult_rr_sched: round-robin arbiter in front of one pipelined
// signed fixed-point multiplier shared by NREQ requesters.
// One issue per cycle; response returns LATENCY cycles after issue as a
// one-hot pulse to the issuing requester.
// Optional build macro: FIXED_P_SMULT_SAT_EN (saturate instead of wrap at
// the final stage; latency is the same either way).
module fixed_p_smult_rr_sched #(
   parameter int WIDTH       = 32,
   parameter int INT_WIDTH   = 8,
   parameter int FRACT_WIDTH = 24,
   parameter int NREQ        = 4,
   parameter int LATENCY     = 3
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NREQ-1:0]         req_valid,
   output logic [NREQ-1:0]         req_ready,
   input  logic [NREQ*WIDTH-1:0]   req_left,
   input  logic [NREQ*WIDTH-1:0]   req_right,
   output logic [NREQ-1:0]         resp_valid,
   output logic [WIDTH-1:0]        resp_out,
   output logic                    busy
);

   localparam int PW  = $clog2(NREQ);
   // MSB of the fixed-point result slice inside the 2*WIDTH product
   localparam int MSB = INT_WIDTH + 2*FRACT_WIDTH - 1;

   logic [PW-1:0]            rr_ptr_q, rr_ptr_d;
   logic [PW-1:0]            gnt;
   logic                     found;
   logic                     issue;
   int                       idx;

   logic signed [WIDTH-1:0]   opl, opr;
   logic signed [2*WIDTH-1:0] prod_c;

   // inputs to the final (truncate/saturate) stage
   logic                      fin_vld;
   logic [PW-1:0]             fin_tag;
   logic [2*WIDTH-1:0]        fin_prod;
   logic                      mid_busy;

   logic                      resp_vld_q;
   logic [PW-1:0]             resp_tag_q;
   logic [WIDTH-1:0]          resp_out_q;
   logic [WIDTH-1:0]          res_c;

   // Round-robin search: first valid requester at or above rr_ptr, wrapping
   always_comb begin
      found = 1'b0;
      gnt   = '0;
      idx   = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(rr_ptr_q) + k) % NREQ;
         if (!found && req_valid[idx]) begin
            found = 1'b1;
            gnt   = PW'(idx);
         end
      end
   end

   // No grants while reset is held, so nothing can issue into a cleared pipe
   assign issue     = found & reset;
   assign req_ready = issue ? (NREQ'(1) << gnt) : '0;

   // Pointer moves just past the winner on issue, otherwise holds
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (issue) rr_ptr_d = (gnt == PW'(NREQ-1)) ? '0 : gnt + PW'(1);
   end

   // Round-robin pointer register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) rr_ptr_q <= '0;
      else        rr_ptr_q <= rr_ptr_d;
   end

   assign opl    = req_left [gnt*WIDTH +: WIDTH];
   assign opr    = req_right[gnt*WIDTH +: WIDTH];
   assign prod_c = opl * opr;

   generate
      if (LATENCY == 1) begin : g_direct
         assign fin_vld  = issue;
         assign fin_tag  = gnt;
         assign fin_prod = prod_c;
         assign mid_busy = 1'b0;
      end else begin : g_pipe
         logic [LATENCY-2:0]              vld_q;
         logic [LATENCY-2:0][PW-1:0]      tag_q;
         logic [LATENCY-2:0][2*WIDTH-1:0] prod_q;

         // Stage 1 captures the full product; later stages just shift
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               vld_q  <= '0;
               tag_q  <= '0;
               prod_q <= '0;
            end else begin
               vld_q[0]  <= issue;
               tag_q[0]  <= gnt;
               prod_q[0] <= prod_c;
               for (int k = 1; k < LATENCY-1; k++) begin
                  vld_q[k]  <= vld_q[k-1];
                  tag_q[k]  <= tag_q[k-1];
                  prod_q[k] <= prod_q[k-1];
               end
            end
         end

         assign fin_vld  = vld_q[LATENCY-2];
         assign fin_tag  = tag_q[LATENCY-2];
         assign fin_prod = prod_q[LATENCY-2];
         assign mid_busy = |vld_q;
      end
   endgenerate

`ifdef FIXED_P_SMULT_SAT_EN
   // Bits above the result MSB must all match the result sign, else overflow
   logic [2*WIDTH-1-MSB:0] hi;
   logic                   unused_prod_lo;
   assign hi             = fin_prod[2*WIDTH-1:MSB];
   assign unused_prod_lo = ^fin_prod[FRACT_WIDTH-1:0];

   // Clamp toward the sign of the true product on overflow
   always_comb begin
      res_c = fin_prod[MSB:FRACT_WIDTH];
      if (!(&hi || ~|hi))
         res_c = fin_prod[2*WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                     : {1'b0, {(WIDTH-1){1'b1}}};
   end
`else
   // Plain slice: floor toward -inf, wraps on overflow
   logic unused_prod_bits;
   assign unused_prod_bits = ^{fin_prod[2*WIDTH-1:MSB+1], fin_prod[FRACT_WIDTH-1:0]};
   assign res_c            = fin_prod[MSB:FRACT_WIDTH];
`endif

   // Final stage: one-cycle response pulse, result held between responses
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         resp_vld_q <= 1'b0;
         resp_tag_q <= '0;
         resp_out_q <= '0;
      end else begin
         resp_vld_q <= fin_vld;
         if (fin_vld) begin
            resp_tag_q <= fin_tag;
            resp_out_q <= res_c;
         end
      end
   end

   assign resp_valid = resp_vld_q ? (NREQ'(1) << resp_tag_q) : '0;
   assign resp_out   = resp_out_q;
   assign busy       = mid_busy | resp_vld_q;

endmodule

// File: tb/tb_fixed_p_smult_rr_sched.sv
// Bench for fixed_p_smult_rr_sched: directed cases plus random traffic,
// with a queue-based scoreboard and an independent response monitor.
module tb_fixed_p_smult_rr_sched;

   localparam int W = 32;
   localparam int N = 4;
   localparam int L = 3;

   logic           clk = 1'b0;
   logic           reset = 1'b0;
   logic [N-1:0]   req_valid = '0;
   logic [N*W-1:0] req_left = '0;
   logic [N*W-1:0] req_right = '0;
   logic [N-1:0]   req_ready;
   logic [N-1:0]   resp_valid;
   logic [W-1:0]   resp_out;
   logic           busy;

   fixed_p_smult_rr_sched #(.WIDTH(W), .INT_WIDTH(8), .FRACT_WIDTH(24),
                            .NREQ(N), .LATENCY(L)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_left(req_left), .req_right(req_right), .resp_valid(resp_valid),
      .resp_out(resp_out), .busy(busy));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          tag;
      logic [31:0] val;
      int          cyc;
   } exp_t;

   exp_t        sbq[$];
   int          iss_q[$];
   int          mptr = 0;
   logic [31:0] last_out = '0;
   int          total = 0;
   int          bad = 0;

   task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", nm, a, e, cyc);
      end
   endtask

   // Reference: exact 64-bit product, arithmetic shift by the fraction width
   function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
      longint p, q;
      p = longint'($signed(a)) * longint'($signed(b));
      q = p >>> 24;
`ifdef FIXED_P_SMULT_SAT_EN
      if (q > 64'sd2147483647)       q = 64'sd2147483647;
      else if (q < -64'sd2147483648) q = -64'sd2147483648;
`endif
      return q[31:0];
   endfunction

   function automatic logic [31:0] rop();
      if ($urandom_range(0, 1) == 1) return $urandom;
      return 32'($urandom_range(0, 32'h0FFF_FFFF)) - 32'h0800_0000;
   endfunction

   // One cycle of stimulus; checks the grant and records the expected response
   task automatic drive(input logic [N-1:0] v, input logic [N*W-1:0] l,
                        input logic [N*W-1:0] r, input bit rst);
      int g;
      logic [N-1:0] er;
      @(posedge clk);
      #1;
      reset     = rst;
      req_valid = v;
      req_left  = l;
      req_right = r;
      if (!rst) begin
         sbq.delete();
         iss_q.delete();
         mptr     = 0;
         last_out = '0;
      end
      #2;
      g = -1;
      if (rst)
         for (int k = 0; k < N; k++)
            if (g < 0 && v[(mptr + k) % N]) g = (mptr + k) % N;
      er = (g >= 0) ? (N'(1) << g) : '0;
      chk("req_ready", req_ready, er);
      if (g >= 0) begin
         exp_t e;
         e.tag = g;
         e.val = ref_mul(l[g*W +: W], r[g*W +: W]);
         e.cyc = cyc;
         sbq.push_back(e);
         iss_q.push_back(cyc);
         mptr = (g + 1) % N;
      end
   endtask

   // Monitor: busy window, response order/latency/value, hold when idle
   initial begin
      exp_t e;
      bit   eb;
      forever begin
         @(negedge clk);
         while (iss_q.size() > 0 && iss_q[0] < cyc - L) void'(iss_q.pop_front());
         eb = (iss_q.size() > 0) && (iss_q[0] <= cyc - 1);
         chk("busy", busy, eb);
         if (resp_valid != '0) begin
            if (sbq.size() == 0) chk("resp_unexpected", resp_valid, 0);
            else begin
               e = sbq.pop_front();
               chk("resp_valid", resp_valid, N'(1) << e.tag);
               chk("resp_out", resp_out, e.val);
               chk("resp_latency", cyc - e.cyc, L);
               last_out = e.val;
            end
         end else begin
            chk("resp_out_hold", resp_out, last_out);
            if (sbq.size() > 0 && sbq[0].cyc + L <= cyc) begin
               e = sbq.pop_front();
               chk("resp_missing", resp_valid, N'(1) << e.tag);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [N*W-1:0] l, r;
      logic [N-1:0]   v;
      repeat (3) drive('0, '0, '0, 1'b0);
      drive('0, '0, '0, 1'b1);

      // 1.5 * 2.0 on requester 0
      l = '0; r = '0;
      l[0 +: W] = 32'h0180_0000; r[0 +: W] = 32'h0200_0000;
      drive(4'b0001, l, r, 1'b1);
      repeat (4) drive('0, '0, '0, 1'b1);

      // -1.5 * 2.0 on requester 2 (pointer sits at 1)
      l = '0; r = '0;
      l[2*W +: W] = 32'hFE80_0000; r[2*W +: W] = 32'h0200_0000;
      drive(4'b0100, l, r, 1'b1);
      repeat (4) drive('0, '0, '0, 1'b1);

      // overflow cases: 100*2 on req 1, -100*2 on req 3, back to back
      l = '0; r = '0;
      l[1*W +: W] = 32'h6400_0000; r[1*W +: W] = 32'h0200_0000;
      drive(4'b0010, l, r, 1'b1);
      l[3*W +: W] = 32'h9C00_0000; r[3*W +: W] = 32'h0200_0000;
      drive(4'b1000, l, r, 1'b1);
      repeat (4) drive('0, '0, '0, 1'b1);

      // single requester held continuously with pointer elsewhere
      for (int i = 0; i < 5; i++) begin
         l[1*W +: W] = rop(); r[1*W +: W] = rop();
         drive(4'b0010, l, r, 1'b1);
      end
      repeat (4) drive('0, '0, '0, 1'b1);

      // all four active straight out of reset with distinct operands
      for (int i = 0; i < N; i++) begin
         l[i*W +: W] = 32'(i + 1) * 32'h0080_0000;
         r[i*W +: W] = 32'h0300_0000 - 32'(i) * 32'h0100_0000;
      end
      repeat (2) drive(4'b1111, l, r, 1'b0);
      repeat (9) drive(4'b1111, l, r, 1'b1);
      repeat (4) drive('0, '0, '0, 1'b1);

      // reset mid-flight: in-flight ops must vanish, grant restarts at 0
      repeat (3) drive(4'b0001, l, r, 1'b1);
      repeat (2) drive(4'b1110, l, r, 1'b0);
      drive(4'b1111, l, r, 1'b1);
      repeat (6) drive('0, '0, '0, 1'b1);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 3))
            0: v = N'($urandom);
            1: v = '1;
            2: v = N'(1) << $urandom_range(0, N-1);
            default: v = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
         endcase
         for (int k = 0; k < N; k++) begin
            l[k*W +: W] = rop();
            r[k*W +: W] = rop();
         end
         drive(v, l, r, 1'b1);
      end
      repeat (6) drive('0, '0, '0, 1'b1);
      chk("drain", sbq.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fixed_p_smult_rr_sched.md
Name: fixed_p_smult_rr_sched

Overview:
- Shares one pipelined signed fixed-point multiplier among NREQ requesters.
- Requester selection is round-robin.
- Multiply semantics: full 2*WIDTH-bit signed product; result bits [WIDTH+FRACT_WIDTH-1:FRACT_WIDTH].
- Sits between several Calyx-generated groups and a single multiplier; lets them time-share it at one issue per cycle.

Parameters:
- WIDTH, 32, operand/result width.
- INT_WIDTH, 8, integer bits (WIDTH = INT_WIDTH + FRACT_WIDTH).
- FRACT_WIDTH, 24, fraction bits.
- NREQ, 4, number of requesters (>= 2).
- LATENCY, 3, cycles from issue to response (>= 1).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  NREQ  per-requester operation request.
- req_ready  output  NREQ  one-hot grant; issue when req_valid[i] && req_ready[i].
- req_left  input  NREQ*WIDTH  signed left operands, requester i at [i*WIDTH +: WIDTH].
- req_right  input  NREQ*WIDTH  signed right operands, same packing.
- resp_valid  output  NREQ  one-hot, 1-cycle pulse to the requester owning resp_out.
- resp_out  output  WIDTH  signed fixed-point product.
- busy  output  1  any operation in flight.

Behaviour:
- Reset (reset low, async):
  - rr_ptr=0; all pipeline valid/tag/data registers=0.
  - resp_valid=0, resp_out=0, busy=0.
  - req_ready=0 while reset asserted.
- Arbitration (combinational):
  - Grant is the first requester with req_valid set, searching from rr_ptr upward, wrapping mod NREQ.
  - req_ready is one-hot of that grant, or all-zero when no request.
  - Max one issue per cycle.
  - On issue, rr_ptr <= grant+1 mod NREQ; otherwise rr_ptr holds.
  - Requester must hold req_valid/operands stable until its handshake cycle.
  - Deasserting req_valid without a handshake is allowed and drops the request.
- Pipeline: LATENCY-deep shift register of {valid, tag (clog2 NREQ bits), data}.
  - Stage 1 captures the full signed product of the granted operands.
  - Truncation/saturation is applied at the final stage.
  - Issue at cycle t -> resp_valid[tag] high and resp_out valid in cycle t+LATENCY, for exactly 1 cycle.
  - Throughput 1 op/cycle. No output backpressure; requester must accept.
  - resp_out holds last value when resp_valid=0.
- Arithmetic:
  - product = $signed(left)*$signed(right), 2*WIDTH bits.
  - Default result = product[WIDTH+FRACT_WIDTH-1:FRACT_WIDTH]: truncation toward -inf, wrap on overflow.
- busy = OR of all stage valids.
- Boundary conditions:
  - Single requester asserting continuously is granted every cycle, even when rr_ptr points elsewhere.
  - All requesters continuously active -> grants 0,1,...,NREQ-1,0,...
  - Same requester may have up to LATENCY ops in flight; responses return in issue order.
  - Reset mid-operation discards all in-flight ops; no resp_valid pulses after reset release for ops issued before reset.

Optional Feature:
- Macro: FIXED_P_SMULT_SAT_EN.
- Defined: final stage checks product bits [2*WIDTH-1:WIDTH+FRACT_WIDTH-1].
  - Not all equal -> clamp to max positive (0x7FF..F) when product < 0 is false, else to min negative (0x800..0).
  - All equal -> truncated value as default.
- Undefined: plain wrap truncation, no compare logic.
- Latency identical in both builds.

Test Plan (WIDTH=32, FRACT_WIDTH=24, NREQ=4, LATENCY=3):
- Req 0 only, left=0x01800000 (1.5), right=0x02000000 (2.0), issue cycle t -> resp_valid=0001 at t+3, resp_out=0x03000000; busy high t+1..t+3.
- Req 2 only, 0xFE800000 (-1.5) * 0x02000000 -> resp_valid=0100, resp_out=0xFD000000 (-3.0).
- 0x64000000 (100.0) * 0x02000000 (2.0) -> without macro resp_out=0xC8000000 (-56.0); with FIXED_P_SMULT_SAT_EN resp_out=0x7FFFFFFF. 0x9C000000 (-100.0) * 0x02000000 with SAT -> 0x80000000.
- All four req_valid held high from reset release with distinct operands -> req_ready sequence 0001,0010,0100,1000,0001; responses in same order, 3 cycles behind, one per cycle, each resp_out matching its requester's operands.
- Issue 3 ops back-to-back, assert reset one cycle later for 2 cycles -> resp_valid stays 0 during and after reset, busy=0, next grant goes to requester 0.
